aec_infix2postfix: RTL

- Front stage of the AEC datapath: captures one ASCII infix expression and converts it to a postfix token stream using a shunting-yard operator stack.
- Feeds the postfix evaluator, which produces `valid`/`result`.
- Input side matches the AEC character protocol:
  - `ready` pulses with the first character.
  - One character arrives per cycle, with no backpressure.
  - The expression ends with `'='`.
- Output side is a valid/ready token handshake.

---
 rtl/aec_pkg.sv | 104 ++++++++++
 rtl/aec_op_stack.sv | 66 ++++++
 rtl/aec_infix2postfix.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aec_pkg.sv
// Shared types and helpers for the AEC infix-to-postfix front stage.
//   op_e       - operator token codes carried on tok_data
//   token_t    - registered output token {is_op, data}
//   state_e    - converter FSM states
//   ch_class_e - decoded character classes
//   prec()     - operator-stack precedence
//   classify(), operand_val(), op_code() - ASCII decode helpers
package aec_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_END = 2'd3
    } op_e;

    // The stack never holds END, so its code doubles as the '(' marker.
    localparam logic [1:0] STK_LPAREN = 2'd3;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_A      = 8'h61;
    localparam logic [7:0] ASCII_F      = 8'h66;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;

    typedef struct packed {
        logic       is_op;
        logic [3:0] data;
    } token_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CONV,
        FLUSH,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        CH_OPERAND,
        CH_OP,
        CH_LPAREN,
        CH_RPAREN,
        CH_EQ,
        CH_BAD
    } ch_class_e;

    function automatic logic [1:0] prec(input logic [1:0] code);
        logic [1:0] p;
        case (code)
            OP_MUL:     p = 2'd2;
            OP_ADD,
            OP_SUB:     p = 2'd1;
            default:    p = 2'd0;  // '('
        endcase
        return p;
    endfunction

    function automatic ch_class_e classify(input logic [7:0] ch);
        ch_class_e c;
        if ((ch >= ASCII_0 && ch <= ASCII_9) || (ch >= ASCII_A && ch <= ASCII_F)) begin
            c = CH_OPERAND;
        end else begin
            case (ch)
                ASCII_PLUS,
                ASCII_MINUS,
                ASCII_STAR:   c = CH_OP;
                ASCII_LPAREN: c = CH_LPAREN;
                ASCII_RPAREN: c = CH_RPAREN;
                ASCII_EQ:     c = CH_EQ;
                default:      c = CH_BAD;
            endcase
        end
        return c;
    endfunction

    // Only meaningful for CH_OPERAND characters.
    function automatic logic [3:0] operand_val(input logic [7:0] ch);
        logic [3:0] v;
        if (ch <= ASCII_9) begin
            v = ch[3:0];
        end else begin
            v = ch[3:0] + 4'd9;  // 'a' = 0x61 -> 10
        end
        return v;
    endfunction

    // Only meaningful for CH_OP characters.
    function automatic op_e op_code(input logic [7:0] ch);
        op_e o;
        case (ch)
            ASCII_MINUS: o = OP_SUB;
            ASCII_STAR:  o = OP_MUL;
            default:     o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aec_op_stack.sv
// Parameterized LIFO used as the shunting-yard operator stack.
//   clk, rst    - clock, asynchronous active-low reset (clears the stack pointer)
//   push, din   - push din (ignored when full)
//   pop         - pop top (ignored when empty)
//   push & pop  - on a non-empty stack, replaces the top entry with din
//   top         - current top entry ('0 when empty)
//   empty, full - occupancy flags
module aec_op_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [AW-1:0]    top_idx;
    logic             replace;
    logic             do_push;
    logic             do_pop;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    assign top_idx = AW'(sp_q - PW'(1));
    assign replace = push & pop & ~empty;
    assign do_push = push & ~replace & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign top     = empty ? '0 : mem[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + PW'(1);
        end else if (do_pop) begin
            sp_d = sp_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage is not reset; only entries below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (replace) begin
            mem[top_idx] <= din;
        end else if (do_push) begin
            mem[AW'(sp_q)] <= din;
        end
    end

endmodule

// File: rtl/aec_infix2postfix.sv
// AEC front stage: captures one ASCII infix expression (terminated by '=') and
// converts it to a postfix token stream with a shunting-yard operator stack.
//   clk, rst   - clock, asynchronous active-low reset
//   ready      - start strobe; ascii_in holds the first character in that cycle
//   ascii_in   - expression character, one per cycle, no backpressure
//   tok_valid  - registered token available
//   tok_ready  - downstream accepts the token
//   tok_is_op  - 1 = operator/END token, 0 = operand
//   tok_data   - operand 0..15 or op code (0 '+', 1 '-', 2 '*', 3 END)
//   busy       - high from capture start until END is accepted
//   err        - sticky per expression: overflow, bad character or paren mismatch
module aec_infix2postfix
    import aec_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] ascii_in,
    output logic       tok_valid,
    input  logic       tok_ready,
    output logic       tok_is_op,
    output logic [3:0] tok_data,
    output logic       busy,
    output logic       err
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned PW = $clog2(MAX_LEN + 1);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          tok_valid_q, tok_valid_d;
    token_t        tok_q, tok_d;

    logic [7:0]    char_buf [MAX_LEN];
    logic          buf_we;
    logic [AW-1:0] buf_waddr;

    logic          stk_push, stk_pop;
    logic [1:0]    stk_din, stk_top;
    logic          stk_empty, stk_full;

    logic          step;
    logic          acted;
    logic          emit;
    token_t        emit_tok;
    logic          do_flush;
    logic [7:0]    cur_ch;
    ch_class_e     cur_class;
    op_e           cur_op;

    aec_op_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (2)
    ) u_op_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

    // Running past the captured characters (truncated input) behaves as '='.
    assign cur_ch    = (rd_ptr_q < wr_ptr_q) ? char_buf[AW'(rd_ptr_q)] : ASCII_EQ;
    assign cur_class = classify(cur_ch);
    assign cur_op    = op_code(cur_ch);

    // A conversion step may only overwrite the output register once it is free.
    assign step = ~tok_valid_q | tok_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;
        busy_d      = busy_q;
        tok_valid_d = tok_valid_q;
        tok_d       = tok_q;
        buf_we      = 1'b0;
        buf_waddr   = '0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_din     = '0;
        acted       = 1'b0;
        emit        = 1'b0;
        emit_tok    = '0;
        do_flush    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    wr_ptr_d  = PW'(1);
                    rd_ptr_d  = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = (ascii_in == ASCII_EQ) ? CONV : RECV;
                end
            end
            RECV: begin
                if (wr_ptr_q < PW'(MAX_LEN)) begin
                    buf_we    = 1'b1;
                    buf_waddr = AW'(wr_ptr_q);
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                end else begin
                    err_d = 1'b1;
                end
                if (ascii_in == ASCII_EQ) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (step) begin
                    acted = 1'b1;
                    unique case (cur_class)
                        CH_OPERAND: begin
                            emit     = 1'b1;
                            emit_tok = '{is_op: 1'b0, data: operand_val(cur_ch)};
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                        CH_LPAREN: begin
                            if (stk_full) begin
                                err_d = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                                stk_din  = STK_LPAREN;
                            end
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                        CH_RPAREN: begin
                            // Unwind one operator per step until the matching '('.
                            if (stk_empty) begin
                                err_d    = 1'b1;
                                rd_ptr_d = rd_ptr_q + PW'(1);
                            end else if (stk_top == STK_LPAREN) begin
                                stk_pop  = 1'b1;
                                rd_ptr_d = rd_ptr_q + PW'(1);
                            end else begin
                                stk_pop  = 1'b1;
                                emit     = 1'b1;
                                emit_tok = '{is_op: 1'b1, data: {2'b00, stk_top}};
                            end
                        end
                        CH_OP: begin
                            // >= gives left associativity for equal precedence.
                            if (!stk_empty && (prec(stk_top) >= prec(cur_op))) begin
                                stk_pop  = 1'b1;
                                emit     = 1'b1;
                                emit_tok = '{is_op: 1'b1, data: {2'b00, stk_top}};
                            end else begin
                                if (stk_full) begin
                                    err_d = 1'b1;
                                end else begin
                                    stk_push = 1'b1;
                                    stk_din  = cur_op;
                                end
                                rd_ptr_d = rd_ptr_q + PW'(1);
                            end
                        end
                        CH_EQ: begin
                            // Start flushing in this same step to avoid a bubble.
                            do_flush = 1'b1;
                        end
                        default: begin
                            err_d    = 1'b1;
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                    endcase
                end
            end
            FLUSH: begin
                if (step) begin
                    acted    = 1'b1;
                    do_flush = 1'b1;
                end
            end
            DONE: begin
                if (tok_ready) begin
                    tok_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_flush) begin
            if (stk_empty) begin
                emit     = 1'b1;
                emit_tok = '{is_op: 1'b1, data: {2'b00, OP_END}};
                state_d  = DONE;
            end else begin
                stk_pop = 1'b1;
                state_d = FLUSH;
                if (stk_top == STK_LPAREN) begin
                    err_d = 1'b1;
                end else begin
                    emit     = 1'b1;
                    emit_tok = '{is_op: 1'b1, data: {2'b00, stk_top}};
                end
            end
        end

        if (acted) begin
            tok_valid_d = emit;
            if (emit) begin
                tok_d = emit_tok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            tok_valid_q <= tok_valid_d;
            tok_q       <= tok_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            char_buf[buf_waddr] <= ascii_in;
        end
    end

    assign tok_valid = tok_valid_q;
    assign tok_is_op = tok_q.is_op;
    assign tok_data  = tok_q.data;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
